// File: rtl/ethhelper_pkg.sv
// Shared definitions for the R-channel stream packer: output phase encoding,
// metadata field placement and stream type tags.
package ethhelper_pkg;

    typedef enum logic {
        PH_DATA = 1'b0,
        PH_META = 1'b1
    } phase_e;

    localparam int META_RID_LSB = 0;

    // Metadata fields sit directly above the RID, so their offsets depend on ID width.
    function automatic int meta_resp_lsb(input int id_width);
        return id_width;
    endfunction

    function automatic int meta_last_bit(input int id_width);
        return id_width + 2;
    endfunction

    function automatic int meta_type_lsb(input int id_width);
        return id_width + 3;
    endfunction

    localparam logic [2:0] STREAM_TYPE_R = 3'b000;

endpackage

// File: rtl/axi_r_stream_packer_if.sv
// Bus bundle for the packer: captured R-channel beat in, back-pressure to the
// interposer, and the AXI-Stream master out.
interface axi_r_stream_packer_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 32
);
    logic                  in_valid;
    logic [ID_WIDTH-1:0]   in_rid;
    logic [DATA_WIDTH-1:0] in_rdata;
    logic [1:0]            in_rresp;
    logic                  in_rlast;
    logic                  can_forwardR;
    logic                  m_axis_tvalid;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    modport slave (
        input  in_valid, in_rid, in_rdata, in_rresp, in_rlast, m_axis_tready,
        output can_forwardR, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );

    modport master (
        output in_valid, in_rid, in_rdata, in_rresp, in_rlast, m_axis_tready,
        input  can_forwardR, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
endinterface

// File: rtl/r_beat_fifo.sv
// Small synchronous beat buffer; pushes while full and pops while empty are ignored.
module r_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/axi_r_stream_packer.sv
// Buffers captured R beats and emits each one as a data word followed by a
// metadata word on an AXI-Stream master; counts completed bursts.
module axi_r_stream_packer
    import ethhelper_pkg::*;
#(
    parameter int                           DATA_WIDTH        = 128,
    parameter int                           ID_WIDTH          = 32,
    parameter int                           STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE       = STREAM_TYPE_WIDTH'(STREAM_TYPE_R),
    parameter int                           FIFO_DEPTH        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    axi_r_stream_packer_if.slave  bus,
    output logic [15:0]           burst_count,
    output logic                  overflow_err
);
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;
    localparam int META_RESP_LSB = meta_resp_lsb(ID_WIDTH);
    localparam int META_LAST_BIT = meta_last_bit(ID_WIDTH);
    localparam int META_TYPE_LSB = meta_type_lsb(ID_WIDTH);

    if (DATA_WIDTH < ID_WIDTH + STREAM_TYPE_WIDTH + 3) begin : g_bad_width
        $error("axi_r_stream_packer: DATA_WIDTH too narrow for metadata word");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axi_r_stream_packer: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef struct packed {
        logic [ID_WIDTH-1:0]   rid;
        logic [1:0]            rresp;
        logic                  rlast;
        logic [DATA_WIDTH-1:0] rdata;
    } beat_t;

    beat_t             in_beat, head;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    phase_e            phase_q, phase_d;
    logic [15:0]       burst_count_q, burst_count_d;
    logic              overflow_q, overflow_d;
    logic              tvalid, tlast, handshake;
    logic [DATA_WIDTH-1:0] meta_word, tdata;

    assign in_beat = '{rid: bus.in_rid, rresp: bus.in_rresp, rlast: bus.in_rlast, rdata: bus.in_rdata};

    r_beat_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.in_valid),
        .pop   (fifo_pop),
        .wdata (in_beat),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Permission follows registered occupancy only; a pop this cycle does not free a slot early.
    assign bus.can_forwardR = !reset && (fifo_count < CNT_W'(FIFO_DEPTH));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        meta_word = '0;
        meta_word[META_RID_LSB +: ID_WIDTH]           = head.rid;
        meta_word[META_RESP_LSB +: 2]                 = head.rresp;
        meta_word[META_LAST_BIT]                      = head.rlast;
        meta_word[META_TYPE_LSB +: STREAM_TYPE_WIDTH] = STREAM_TYPE;
    end

    always_comb begin
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = '0;
        if (phase_q == PH_META) begin
            tvalid = 1'b1;
            tlast  = head.rlast;
            tdata  = meta_word;
        end else if (!fifo_empty) begin
            tvalid = 1'b1;
            tdata  = head.rdata;
        end
    end

    assign handshake = tvalid && bus.m_axis_tready;
    assign fifo_pop  = handshake && (phase_q == PH_META);

    always_comb begin
        phase_d       = phase_q;
        burst_count_d = burst_count_q;
        overflow_d    = overflow_q || (bus.in_valid && fifo_full);
        if (handshake) begin
            if (phase_q == PH_DATA) begin
                phase_d = PH_META;
            end else begin
                phase_d = PH_DATA;
                if (head.rlast) burst_count_d = burst_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= PH_DATA;
            burst_count_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            burst_count_q <= burst_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tdata  = tdata;
    assign bus.m_axis_tlast  = tlast;
    assign burst_count       = burst_count_q;
    assign overflow_err      = overflow_q;
endmodule

// File: tb/tb_axi_r_stream_packer.sv
// Directed bench for axi_r_stream_packer: reset, single beat, overflow,
// stalls, concurrent push/pop, reset mid-pair and burst counter wrap.
module tb_axi_r_stream_packer;
    localparam int DW = 128;
    localparam int IW = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] burst_count;
    logic        overflow_err;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    axi_r_stream_packer_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) bus_if ();

    axi_r_stream_packer #(
        .DATA_WIDTH        (DW),
        .ID_WIDTH          (IW),
        .STREAM_TYPE_WIDTH (3),
        .STREAM_TYPE       (3'b000),
        .FIFO_DEPTH        (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .burst_count  (burst_count),
        .overflow_err (overflow_err)
    );

    function automatic logic [DW-1:0] meta(input logic [IW-1:0] rid, input logic [1:0] resp, input logic last);
        logic [DW-1:0] m;
        m = '0;
        m[IW-1:0]   = rid;
        m[IW +: 2]  = resp;
        m[IW+2]     = last;
        return m;
    endfunction

    task automatic push_beat(input logic [IW-1:0] rid, input logic [DW-1:0] data,
                             input logic [1:0] resp, input logic last);
        bus_if.in_valid = 1'b1;
        bus_if.in_rid   = rid;
        bus_if.in_rdata = data;
        bus_if.in_rresp = resp;
        bus_if.in_rlast = last;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
    endtask

    // Waits (bounded) for a valid word with tready high, returns it once the handshake edge has passed.
    task automatic get_word(output logic [DW-1:0] d, output logic l, output bit ok);
        ok = 1'b0;
        d  = '0;
        l  = 1'b0;
        bus_if.m_axis_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.m_axis_tvalid === 1'b1) begin
                d  = bus_if.m_axis_tdata;
                l  = bus_if.m_axis_tlast;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus_if.in_valid = 1'b0; bus_if.in_rid = '0; bus_if.in_rdata = '0;
        bus_if.in_rresp = '0; bus_if.in_rlast = 1'b0; bus_if.m_axis_tready = 1'b0;
        #1 reset = 1'b1;
        #2;
        vectors++; if (bus_if.can_forwardR !== 1'b0) begin miscompares++; $display("FAIL reset_cfr got=%b want=0", bus_if.can_forwardR); end
        vectors++; if (bus_if.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got=%b want=0", bus_if.m_axis_tvalid); end
        vectors++; if (bus_if.m_axis_tdata !== '0) begin miscompares++; $display("FAIL reset_tdata got=%h want=0", bus_if.m_axis_tdata); end
        vectors++; if (bus_if.m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got=%b want=0", bus_if.m_axis_tlast); end
        vectors++; if (burst_count !== 16'h0) begin miscompares++; $display("FAIL reset_burst got=%h want=0", burst_count); end
        vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got=%b want=0", overflow_err); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (bus_if.can_forwardR !== 1'b1) begin miscompares++; $display("FAIL post_reset_cfr got=%b want=1", bus_if.can_forwardR); end
        @(negedge clk);
    endtask

    task automatic test_single_beat();
        bus_if.m_axis_tready = 1'b1;
        push_beat(32'h5, 128'hDEADBEEF, 2'd0, 1'b1);
        vectors++; if (bus_if.m_axis_tvalid !== 1'b1 || bus_if.m_axis_tdata !== 128'hDEADBEEF || bus_if.m_axis_tlast !== 1'b0) begin
            miscompares++; $display("FAIL single_data got v=%b d=%h l=%b want v=1 d=deadbeef l=0", bus_if.m_axis_tvalid, bus_if.m_axis_tdata, bus_if.m_axis_tlast); end
        @(negedge clk);
        vectors++; if (bus_if.m_axis_tvalid !== 1'b1 || bus_if.m_axis_tdata !== 128'h0000_0004_0000_0005 || bus_if.m_axis_tlast !== 1'b1) begin
            miscompares++; $display("FAIL single_meta got v=%b d=%h l=%b want v=1 d=400000005 l=1", bus_if.m_axis_tvalid, bus_if.m_axis_tdata, bus_if.m_axis_tlast); end
        @(negedge clk);
        vectors++; if (bus_if.m_axis_tvalid !== 1'b0 || bus_if.m_axis_tdata !== '0) begin
            miscompares++; $display("FAIL single_idle got v=%b d=%h want v=0 d=0", bus_if.m_axis_tvalid, bus_if.m_axis_tdata); end
        vectors++; if (burst_count !== 16'd1) begin miscompares++; $display("FAIL single_burst got=%0d want=1", burst_count); end
        bus_if.m_axis_tready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d, exp_d;
        logic          l, exp_l;
        bit            ok;
        int            b;
        bus_if.m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_beat(IW'(i + 1), DW'(32'h100 + i), 2'(i), i == 3);
            if (i == 2) begin
                vectors++; if (bus_if.can_forwardR !== 1'b1) begin miscompares++; $display("FAIL ovf_cfr_3 got=%b want=1", bus_if.can_forwardR); end
            end
        end
        vectors++; if (bus_if.can_forwardR !== 1'b0) begin miscompares++; $display("FAIL ovf_cfr_full got=%b want=0", bus_if.can_forwardR); end
        vectors++; if (overflow_err !== 1'b0) begin miscompares++; $display("FAIL ovf_early got=%b want=0", overflow_err); end
        push_beat(32'hFF, 128'hBAD, 2'd3, 1'b1);
        vectors++; if (overflow_err !== 1'b1) begin miscompares++; $display("FAIL ovf_set got=%b want=1", overflow_err); end
        vectors++; if (bus_if.can_forwardR !== 1'b0) begin miscompares++; $display("FAIL ovf_cfr_after got=%b want=0", bus_if.can_forwardR); end
        for (int w = 0; w < 8; w++) begin
            get_word(d, l, ok);
            b = w / 2;
            exp_d = (w % 2 == 0) ? DW'(32'h100 + b) : meta(IW'(b + 1), 2'(b), b == 3);
            exp_l = (w == 7);
            vectors++; if (!ok || d !== exp_d || l !== exp_l) begin
                miscompares++; $display("FAIL ovf_word%0d got ok=%0d d=%h l=%b want d=%h l=%b", w, ok, d, l, exp_d, exp_l); end
        end
        bus_if.m_axis_tready = 1'b0;
        vectors++; if (bus_if.m_axis_tvalid !== 1'b0 || bus_if.m_axis_tdata !== '0) begin
            miscompares++; $display("FAIL ovf_drained got v=%b d=%h want v=0 d=0", bus_if.m_axis_tvalid, bus_if.m_axis_tdata); end
        vectors++; if (burst_count !== 16'd2 || overflow_err !== 1'b1) begin
            miscompares++; $display("FAIL ovf_counts got burst=%0d ovf=%b want burst=2 ovf=1", burst_count, overflow_err); end
    endtask

    task automatic test_stall();
        logic [15:0]   pat = 16'b1011_0010_0110_1001;
        logic [DW-1:0] got_d [6];
        logic          got_l [6];
        logic [DW-1:0] held_d, exp_d;
        logic          held_l, exp_l, prev_stall;
        int            n, stalls;
        n = 0; stalls = 0; prev_stall = 1'b0; held_d = '0; held_l = 1'b0;
        bus_if.m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) push_beat(IW'(32'h10 + i), DW'(32'h2000 + i), 2'd0, i == 2);
        for (int c = 0; c < 64 && n < 6; c++) begin
            bus_if.m_axis_tready = pat[c % 16];
            if (prev_stall) begin
                vectors++; if (bus_if.m_axis_tvalid !== 1'b1 || bus_if.m_axis_tdata !== held_d || bus_if.m_axis_tlast !== held_l) begin
                    miscompares++; $display("FAIL stall_hold c=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", c, bus_if.m_axis_tvalid, bus_if.m_axis_tdata, bus_if.m_axis_tlast, held_d, held_l); end
            end
            prev_stall = 1'b0;
            if (bus_if.m_axis_tvalid === 1'b1) begin
                if (bus_if.m_axis_tready) begin
                    got_d[n] = bus_if.m_axis_tdata;
                    got_l[n] = bus_if.m_axis_tlast;
                    n++;
                end else begin
                    prev_stall = 1'b1;
                    stalls++;
                    held_d = bus_if.m_axis_tdata;
                    held_l = bus_if.m_axis_tlast;
                end
            end
            @(negedge clk);
        end
        bus_if.m_axis_tready = 1'b0;
        vectors++; if (n != 6 || stalls == 0) begin miscompares++; $display("FAIL stall_count got words=%0d stalls=%0d want words=6 stalls>0", n, stalls); end
        for (int k = 0; k < n; k++) begin
            exp_d = (k % 2 == 0) ? DW'(32'h2000 + k / 2) : meta(IW'(32'h10 + k / 2), 2'd0, k == 5);
            exp_l = (k == 5);
            vectors++; if (got_d[k] !== exp_d || got_l[k] !== exp_l) begin
                miscompares++; $display("FAIL stall_word%0d got d=%h l=%b want d=%h l=%b", k, got_d[k], got_l[k], exp_d, exp_l); end
        end
        vectors++; if (bus_if.m_axis_tvalid !== 1'b0 || burst_count !== 16'd3) begin
            miscompares++; $display("FAIL stall_end got v=%b burst=%0d want v=0 burst=3", bus_if.m_axis_tvalid, burst_count); end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [DW-1:0] d, exp_d;
        logic          l, exp_l;
        bit            ok;
        int            b;
        bus_if.m_axis_tready = 1'b0;
        push_beat(32'h21, 128'h3001, 2'd1, 1'b0);
        push_beat(32'h22, 128'h3002, 2'd2, 1'b0);
        vectors++; if (bus_if.can_forwardR !== 1'b1) begin miscompares++; $display("FAIL pp_cfr_2 got=%b want=1", bus_if.can_forwardR); end
        bus_if.m_axis_tready = 1'b1;
        @(negedge clk);
        vectors++; if (bus_if.m_axis_tvalid !== 1'b1 || bus_if.m_axis_tdata !== meta(32'h21, 2'd1, 1'b0)) begin
            miscompares++; $display("FAIL pp_meta got v=%b d=%h want v=1 d=%h", bus_if.m_axis_tvalid, bus_if.m_axis_tdata, meta(32'h21, 2'd1, 1'b0)); end
        push_beat(32'h23, 128'h3003, 2'd3, 1'b0);
        bus_if.m_axis_tready = 1'b0;
        vectors++; if (bus_if.can_forwardR !== 1'b1 || bus_if.m_axis_tdata !== 128'h3002 || bus_if.m_axis_tlast !== 1'b0) begin
            miscompares++; $display("FAIL pp_same got cfr=%b d=%h l=%b want cfr=1 d=3002 l=0", bus_if.can_forwardR, bus_if.m_axis_tdata, bus_if.m_axis_tlast); end
        push_beat(32'h24, 128'h3004, 2'd0, 1'b0);
        vectors++; if (bus_if.can_forwardR !== 1'b1) begin miscompares++; $display("FAIL pp_cfr_3 got=%b want=1", bus_if.can_forwardR); end
        push_beat(32'h25, 128'h3005, 2'd1, 1'b1);
        vectors++; if (bus_if.can_forwardR !== 1'b0) begin miscompares++; $display("FAIL pp_cfr_4 got=%b want=0", bus_if.can_forwardR); end
        for (int w = 0; w < 8; w++) begin
            get_word(d, l, ok);
            b = w / 2 + 2;
            exp_d = (w % 2 == 0) ? DW'(32'h3000 + b) : meta(IW'(32'h20 + b), 2'(b), b == 5);
            exp_l = (w == 7);
            vectors++; if (!ok || d !== exp_d || l !== exp_l) begin
                miscompares++; $display("FAIL pp_word%0d got ok=%0d d=%h l=%b want d=%h l=%b", w, ok, d, l, exp_d, exp_l); end
        end
        bus_if.m_axis_tready = 1'b0;
        vectors++; if (burst_count !== 16'd4) begin miscompares++; $display("FAIL pp_burst got=%0d want=4", burst_count); end
    endtask

    task automatic test_reset_mid_pair();
        bus_if.m_axis_tready = 1'b1;
        push_beat(32'h31, 128'h4001, 2'd0, 1'b1);
        bus_if.in_valid = 1'b1; bus_if.in_rid = 32'h32; bus_if.in_rdata = 128'h4002;
        bus_if.in_rresp = 2'd0; bus_if.in_rlast = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        bus_if.m_axis_tready = 1'b0;
        vectors++; if (bus_if.m_axis_tvalid !== 1'b1 || bus_if.m_axis_tlast !== 1'b1 || bus_if.m_axis_tdata !== meta(32'h31, 2'd0, 1'b1)) begin
            miscompares++; $display("FAIL mid_pre got v=%b l=%b d=%h want v=1 l=1 d=%h", bus_if.m_axis_tvalid, bus_if.m_axis_tlast, bus_if.m_axis_tdata, meta(32'h31, 2'd0, 1'b1)); end
        #1 reset = 1'b1;
        #1;
        vectors++; if (bus_if.m_axis_tvalid !== 1'b0 || bus_if.m_axis_tdata !== '0 || bus_if.m_axis_tlast !== 1'b0 || bus_if.can_forwardR !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset got v=%b d=%h l=%b cfr=%b want all 0", bus_if.m_axis_tvalid, bus_if.m_axis_tdata, bus_if.m_axis_tlast, bus_if.can_forwardR); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        vectors++; if (bus_if.can_forwardR !== 1'b1 || bus_if.m_axis_tvalid !== 1'b0 || burst_count !== 16'd0 || overflow_err !== 1'b0) begin
            miscompares++; $display("FAIL mid_release got cfr=%b v=%b burst=%0d ovf=%b want cfr=1 v=0 burst=0 ovf=0", bus_if.can_forwardR, bus_if.m_axis_tvalid, burst_count, overflow_err); end
        @(negedge clk);
        vectors++; if (bus_if.m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_empty got v=%b want 0", bus_if.m_axis_tvalid); end
    endtask

    task automatic test_burst_wrap();
        logic [DW-1:0] d;
        logic          l;
        bit            ok0, ok1;
        force dut.burst_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.burst_count_q;
        vectors++; if (burst_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload got=%h want=ffff", burst_count); end
        bus_if.m_axis_tready = 1'b1;
        push_beat(32'h41, 128'h5001, 2'd2, 1'b1);
        get_word(d, l, ok0);
        get_word(d, l, ok1);
        bus_if.m_axis_tready = 1'b0;
        vectors++; if (!ok0 || !ok1 || d !== meta(32'h41, 2'd2, 1'b1) || l !== 1'b1) begin
            miscompares++; $display("FAIL wrap_words got ok=%0d%0d d=%h l=%b want d=%h l=1", ok0, ok1, d, l, meta(32'h41, 2'd2, 1'b1)); end
        vectors++; if (burst_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_count got=%h want=0000", burst_count); end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_overflow();
        test_stall();
        test_push_pop_same_cycle();
        test_reset_mid_pair();
        test_burst_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end
endmodule
